cdc_cmd_responder: RTL
======================

// Module: cdc_cmd_responder
// PURPOSE
// - Byte-command responder on the application side of usb_cdc; clocked by the app clock (2 MHz in the SoC).
// - Consumes host->device bytes (the usb_cdc out_* stream) and decodes read/write/error-count commands.
// - Executes each command on a small byte register file and returns one response byte per command on the device->host in_* stream.
// - Register file outputs drive SoC control (LED, pull-up override, etc.).
// PARAMETERS
// - ADDR_W          2     register address width; 2**ADDR_W byte registers
// - TIMEOUT_CYCLES  2000  idle cycles allowed inside a partial frame before abort (1 ms @ 2 MHz)
// PORTS
// - clk_i        in   1              single clock, all logic on posedge
// - rst_i        in   1              reset, asynchronous, active-high
// - out_data_i   in   8              command byte from usb_cdc
// - out_valid_i  in   1              out_data_i valid
// - out_ready_o  out  1              responder can accept a byte
// - in_data_o    out  8              response byte to usb_cdc
// - in_valid_o   out  1              in_data_o valid
// - in_ready_i   in   1              usb_cdc accepts response byte
// - regs_o       out  8*2**ADDR_W    register file, reg k at [8k+7:8k]
// BEHAVIOUR
// - Reset values: out_ready_o=0, in_valid_o=0, in_data_o=8'h00, regs_o=0, state=IDLE, timeout counter=0, error count=0.
// - Byte accept = out_valid_i & out_ready_o. Response transfer = in_valid_o & in_ready_i.
// - out_ready_o: registered; =1 in IDLE/GET_ADDR/GET_DATA, 0 in RESP; first 1 on the cycle after rst_i deasserts.
// - FSM states:
//   - IDLE
//     - 'W'(8'h57) -> GET_ADDR(wr)
//     - 'R'(8'h52) -> GET_ADDR(rd)
//     - any other byte -> RESP with '?'(8'h3F), error count++
//   - GET_ADDR
//     - rd: -> RESP; data = reg[addr], or '?' if addr >= 2**ADDR_W (error count++)
//     - wr: latch addr -> GET_DATA
//   - GET_DATA
//     - on accept: if addr valid, reg[addr] <= byte on the next edge, respond 'K'(8'h4B)
//     - else discard, respond '?', error count++
//     - -> RESP
//   - RESP
//     - in_valid_o=1, in_data_o stable until in_ready_i=1 -> IDLE
//     - in_valid_o drops and out_ready_o rises on the next cycle
// - Latency: last byte of a command accepted in cycle N -> in_valid_o=1 in cycle N+1; write visible on regs_o in N+1.
// - Only one response is ever outstanding; no input is accepted while in RESP (back-pressure to usb_cdc).
// - Timeout:
//   - counter clears on every accepted byte and in IDLE/RESP; increments each cycle in GET_ADDR/GET_DATA.
//   - reaching TIMEOUT_CYCLES-1 -> IDLE; partial frame dropped, no response, no register change, error count++.
//   - counter width = $clog2(TIMEOUT_CYCLES).
// - Simultaneous byte accept and timeout terminal count: the byte wins (counter clears, frame proceeds).
// - Error count: 8-bit, saturates at 8'hFF (no wrap).
// - rst_i mid-frame or mid-response: immediate return to reset values; a pending response is lost.
// CONFIGURATION
// - CDC_CMD_ERRCNT_EN defined:
//   - IDLE also decodes 'E'(8'h45) -> RESP with the current error count, then clears the count to 0 when the response transfers.
// - CDC_CMD_ERRCNT_EN undefined:
//   - no error counter logic; 'E' is an unknown command -> '?'.
// TESTING
// - Write: 'W',8'h01,8'hA5 -> in_data_o=8'h4B one cycle after last byte; regs_o[15:8]=8'hA5; other regs 0.
// - Read back: after write, 'R',8'h01 -> in_data_o=8'hA5; hold in_ready_i=0 for 10 cycles -> in_valid_o/in_data_o stable, out_ready_o=0.
// - Bad input: 'X' -> 8'h3F; 'R',8'h07 with ADDR_W=2 -> 8'h3F.
// - Bad write: 'W',8'h04,8'h55 -> 8'h3F; regs_o unchanged.
// - Timeout:
//   - 'W',8'h00 then idle TIMEOUT_CYCLES -> no response, state IDLE.
//   - a following 'R',8'h00 -> 8'h00.
//   - byte on the terminal-count cycle continues the frame.
// - Reset mid-RESP: assert rst_i while in_valid_o=1 -> in_valid_o=0, regs_o=0 at once; out_ready_o=1 one cycle after release.
// - With CDC_CMD_ERRCNT_EN:
//   - 3 bad commands, then 'E' -> 8'h03; a second 'E' -> 8'h00.
//   - 300 bad commands -> 'E' returns 8'hFF.

Source files
------------

// File: rtl/cdc_cmd_responder_if.sv
// Byte streams between the usb_cdc core and the command responder:
// out_* carries host->device command bytes, in_* carries device->host responses.
interface cdc_cmd_responder_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output out_data, out_valid, in_ready,
    input  out_ready, in_data, in_valid
  );

  modport slave (
    input  out_data, out_valid, in_ready,
    output out_ready, in_data, in_valid
  );
endinterface

// File: rtl/cdc_cmd_responder.sv
// Byte-command responder: decodes 'W'/'R' frames onto a small register file and returns one
// response byte per command. Define CDC_CMD_ERRCNT_EN to add the saturating error counter and the 'E' command.
module cdc_cmd_responder #(
  parameter int unsigned ADDR_W         = 2,
  parameter int unsigned TIMEOUT_CYCLES = 2000
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  cdc_cmd_responder_if.slave        bus,
  output logic [8*(2**ADDR_W)-1:0]  regs_o
);

  localparam int unsigned   NREG    = 2**ADDR_W;
  localparam int unsigned   TO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
  localparam logic [TO_W-1:0] TO_ZERO = TO_W'(0);

  localparam logic [7:0] CH_W = 8'h57;
  localparam logic [7:0] CH_R = 8'h52;
  localparam logic [7:0] CH_K = 8'h4B;
  localparam logic [7:0] CH_Q = 8'h3F;
`ifdef CDC_CMD_ERRCNT_EN
  localparam logic [7:0] CH_E = 8'h45;
`endif

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_GET_ADDR = 2'd1,
    S_GET_DATA = 2'd2,
    S_RESP     = 2'd3
  } state_t;

  function automatic logic addr_ok_f(input logic [7:0] a);
    return ({24'h000000, a} < NREG);
  endfunction

  state_t          state_q, state_d;
  logic            out_ready_q, out_ready_d;
  logic            in_valid_q, in_valid_d;
  logic [7:0]      in_data_q, in_data_d;
  logic            is_wr_q, is_wr_d;
  logic [7:0]      addr_q, addr_d;
  logic [TO_W-1:0] tmo_q, tmo_d;
  logic [7:0]      regs_q [NREG];
  logic [7:0]      regs_d [NREG];

  logic            accept_s;
  logic            resp_done_s;
  logic            in_frame_s;
  logic            timeout_s;

`ifdef CDC_CMD_ERRCNT_EN
  logic [7:0]      errcnt_q, errcnt_d;
  logic            errcmd_q, errcmd_d;
  logic            err_evt_s;
`endif

  assign accept_s    = bus.out_valid & out_ready_q;
  assign resp_done_s = in_valid_q & bus.in_ready;
  assign in_frame_s  = (state_q == S_GET_ADDR) || (state_q == S_GET_DATA);
  // An accepted byte on the terminal-count cycle keeps the frame alive.
  assign timeout_s   = in_frame_s && !accept_s && (tmo_q == TO_LAST);

  assign bus.out_ready = out_ready_q;
  assign bus.in_valid  = in_valid_q;
  assign bus.in_data   = in_data_q;

  for (genvar k = 0; k < NREG; k++) begin : g_regs_out
    assign regs_o[8*k +: 8] = regs_q[k];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          if ((bus.out_data == CH_W) || (bus.out_data == CH_R)) begin
            state_d = S_GET_ADDR;
          end else begin
            state_d = S_RESP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GET_ADDR: begin
        if (accept_s) begin
          state_d = is_wr_q ? S_GET_DATA : S_RESP;
        end else if (timeout_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_GET_ADDR;
        end
      end
      S_GET_DATA: begin
        if (accept_s) begin
          state_d = S_RESP;
        end else if (timeout_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_GET_DATA;
        end
      end
      S_RESP: begin
        if (resp_done_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_ready_d = (state_d != S_RESP);
    in_valid_d  = in_valid_q;
    in_data_d   = in_data_q;
    is_wr_d     = is_wr_q;
    addr_d      = addr_q;
    regs_d      = regs_q;
    if (accept_s || timeout_s || !in_frame_s) begin
      tmo_d = TO_ZERO;
    end else begin
      tmo_d = tmo_q + TO_ONE;
    end
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          if (bus.out_data == CH_W) begin
            is_wr_d = 1'b1;
          end else if (bus.out_data == CH_R) begin
            is_wr_d = 1'b0;
`ifdef CDC_CMD_ERRCNT_EN
          end else if (bus.out_data == CH_E) begin
            in_valid_d = 1'b1;
            in_data_d  = errcnt_q;
`endif
          end else begin
            in_valid_d = 1'b1;
            in_data_d  = CH_Q;
          end
        end else begin
          in_valid_d = 1'b0;
        end
      end
      S_GET_ADDR: begin
        if (accept_s) begin
          if (is_wr_q) begin
            addr_d = bus.out_data;
          end else begin
            in_valid_d = 1'b1;
            in_data_d  = addr_ok_f(bus.out_data) ? regs_q[bus.out_data[ADDR_W-1:0]] : CH_Q;
          end
        end else begin
          addr_d = addr_q;
        end
      end
      S_GET_DATA: begin
        if (accept_s) begin
          in_valid_d = 1'b1;
          if (addr_ok_f(addr_q)) begin
            regs_d[addr_q[ADDR_W-1:0]] = bus.out_data;
            in_data_d = CH_K;
          end else begin
            in_data_d = CH_Q;
          end
        end else begin
          in_valid_d = 1'b0;
        end
      end
      S_RESP: begin
        if (resp_done_s) begin
          in_valid_d = 1'b0;
        end else begin
          in_valid_d = 1'b1;
        end
      end
      default: in_valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_ready_q <= 1'b0;
      in_valid_q  <= 1'b0;
      in_data_q   <= 8'h00;
      is_wr_q     <= 1'b0;
      addr_q      <= 8'h00;
      tmo_q       <= TO_ZERO;
      for (int k = 0; k < NREG; k++) begin
        regs_q[k] <= 8'h00;
      end
    end else begin
      out_ready_q <= out_ready_d;
      in_valid_q  <= in_valid_d;
      in_data_q   <= in_data_d;
      is_wr_q     <= is_wr_d;
      addr_q      <= addr_d;
      tmo_q       <= tmo_d;
      regs_q      <= regs_d;
    end
  end

`ifdef CDC_CMD_ERRCNT_EN
  always_comb begin
    err_evt_s = 1'b0;
    if (timeout_s) begin
      err_evt_s = 1'b1;
    end else if (accept_s) begin
      case (state_q)
        S_IDLE:     err_evt_s = (bus.out_data != CH_W) && (bus.out_data != CH_R) && (bus.out_data != CH_E);
        S_GET_ADDR: err_evt_s = !is_wr_q && !addr_ok_f(bus.out_data);
        S_GET_DATA: err_evt_s = !addr_ok_f(addr_q);
        default:    err_evt_s = 1'b0;
      endcase
    end else begin
      err_evt_s = 1'b0;
    end
  end

  // The count is reported by value, so it only clears once that report has been handed over.
  always_comb begin
    errcnt_d = errcnt_q;
    errcmd_d = errcmd_q;
    if (state_q == S_IDLE && accept_s && bus.out_data == CH_E) begin
      errcmd_d = 1'b1;
    end else if (resp_done_s) begin
      errcmd_d = 1'b0;
    end else begin
      errcmd_d = errcmd_q;
    end
    if (errcmd_q && resp_done_s) begin
      errcnt_d = 8'h00;
    end else if (err_evt_s && (errcnt_q != 8'hFF)) begin
      errcnt_d = errcnt_q + 8'h01;
    end else begin
      errcnt_d = errcnt_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      errcnt_q <= 8'h00;
      errcmd_q <= 1'b0;
    end else begin
      errcnt_q <= errcnt_d;
      errcmd_q <= errcmd_d;
    end
  end
`endif

endmodule
